// File: rtl/branch_info_queue_if.sv
// Alloc / commit / head bundle for the branch info queue.
// master = core side (decoder + ROB), slave = queue.
interface branch_info_queue_if #(
  parameter int PTR_W   = 4,
  parameter int PC_W    = 32,
  parameter int GHIST_W = 8
);
  logic               alloc_valid;
  logic [PC_W-1:0]    alloc_pc;
  logic [GHIST_W-1:0] alloc_ghistory;
  logic               alloc_pred;
  logic               alloc_pred_gshare;
  logic               alloc_pred_2bit;
  logic [PC_W-1:0]    alloc_recovery_target;
  logic               alloc_ready;
  logic [PTR_W-1:0]   alloc_tag;

  logic               commit_valid;
  logic               commit_outcome;
  logic               flush_in;

  logic               head_valid;
  logic [PC_W-1:0]    head_pc;
  logic [GHIST_W-1:0] head_ghistory;
  logic               head_pred_gshare;
  logic               head_pred_2bit;
  logic               mispredict;
  logic [PC_W-1:0]    recovery_target;

  modport master (
    output alloc_valid, alloc_pc, alloc_ghistory,
    output alloc_pred, alloc_pred_gshare, alloc_pred_2bit,
    output alloc_recovery_target,
    output commit_valid, commit_outcome, flush_in,
    input  alloc_ready, alloc_tag,
    input  head_valid, head_pc, head_ghistory,
    input  head_pred_gshare, head_pred_2bit,
    input  mispredict, recovery_target
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_ghistory,
    input  alloc_pred, alloc_pred_gshare, alloc_pred_2bit,
    input  alloc_recovery_target,
    input  commit_valid, commit_outcome, flush_in,
    output alloc_ready, alloc_tag,
    output head_valid, head_pc, head_ghistory,
    output head_pred_gshare, head_pred_2bit,
    output mispredict, recovery_target
  );
endinterface

// File: rtl/branch_info_queue.sv
// In-order circular queue of branch prediction metadata.
// Ports: clk, rst_n, bus (alloc/commit/head), count/full/empty, error + stats.
module branch_info_queue #(
  parameter int DEPTH   = 16,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int PC_W    = 32,
  parameter int GHIST_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_info_queue_if.slave bus,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err_underflow,
  output logic [31:0]      commit_cnt,
  output logic [31:0]      mispredict_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [GHIST_W-1:0] ghist;
    logic               pred;
    logic               pred_gshare;
    logic               pred_2bit;
    logic [PC_W-1:0]    target;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_nxt, rd_nxt;
  logic [PTR_W:0]   cnt_nxt;
  logic             alloc_acc;
  logic             commit_acc;
  logic             mis;
  logic             mis_sq;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  assign head       = mem[rd_ptr];
  assign commit_acc = bus.commit_valid & ~empty;
  assign mis        = commit_acc &
                      (bus.commit_outcome != head.pred);
  // flush wins the pointer update; mispredict alone squashes
  assign mis_sq     = mis & ~bus.flush_in;
  assign alloc_acc  = bus.alloc_valid & ~full &
                      ~bus.flush_in & ~mis;

  assign wr_entry = '{
    pc:          bus.alloc_pc,
    ghist:       bus.alloc_ghistory,
    pred:        bus.alloc_pred,
    pred_gshare: bus.alloc_pred_gshare,
    pred_2bit:   bus.alloc_pred_2bit,
    target:      bus.alloc_recovery_target
  };

  assign bus.alloc_ready = ~full & ~bus.flush_in;
  assign bus.alloc_tag   = wr_ptr;

  assign bus.head_valid       = ~empty;
  assign bus.head_pc          = empty ? '0 : head.pc;
  assign bus.head_ghistory    = empty ? '0 : head.ghist;
  assign bus.head_pred_gshare = ~empty & head.pred_gshare;
  assign bus.head_pred_2bit   = ~empty & head.pred_2bit;
  assign bus.mispredict       = mis;
  assign bus.recovery_target  = mis ? head.target : '0;

  always_comb begin
    wr_nxt  = wr_ptr;
    rd_nxt  = rd_ptr;
    cnt_nxt = count;
    unique case (1'b1)
      bus.flush_in: begin
        wr_nxt  = rd_ptr;
        cnt_nxt = '0;
      end
      mis_sq: begin
        rd_nxt  = wr_ptr;
        cnt_nxt = '0;
      end
      default: begin
        if (alloc_acc)  wr_nxt = wr_ptr + 1'b1;
        if (commit_acc) rd_nxt = rd_ptr + 1'b1;
        cnt_nxt = count
                + (PTR_W+1)'(alloc_acc)
                - (PTR_W+1)'(commit_acc);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_underflow  <= 1'b0;
      commit_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      if (alloc_acc)
        mem[wr_ptr] <= wr_entry;
      if (bus.commit_valid && empty)
        err_underflow <= 1'b1;
      if (commit_acc && commit_cnt != '1)
        commit_cnt <= commit_cnt + 1'b1;
      if (mis && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_info_queue.sv
// Randomised + directed bench for branch_info_queue.
// Reference model: a queue of entries plus tag arithmetic.
module tb_branch_info_queue;
  localparam int D = 16;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  gh;
    bit          pred;
    bit          g;
    bit          b;
    logic [31:0] tgt;
  } ent_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [4:0]  count;
  logic        full, empty, err_underflow;
  logic [31:0] commit_cnt, mispredict_cnt;

  branch_info_queue_if #(.PTR_W(4), .PC_W(32), .GHIST_W(8)) bif();

  branch_info_queue #(.DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bif.slave),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .err_underflow  (err_underflow),
    .commit_cnt     (commit_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];
  int   m_wr = 0;
  bit   m_err = 0;
  longint m_ccnt = 0;
  longint m_mcnt = 0;
  ent_t z;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc,
                              input bit pred,
                              input logic [31:0] tgt);
    ent_t e;
    e.pc   = pc;
    e.gh   = 8'($urandom);
    e.pred = pred;
    e.g    = 1'($urandom);
    e.b    = 1'($urandom);
    e.tgt  = tgt;
    return e;
  endfunction

  function automatic ent_t rnd();
    return mk($urandom, 1'($urandom), $urandom);
  endfunction

  function automatic bit m_mis(input bit cv, input bit co);
    return cv && q.size() > 0 && co != q[0].pred;
  endfunction

  task automatic check_all(input bit cv, input bit co,
                           input bit fl);
    bit   emp = (q.size() == 0);
    bit   mi  = m_mis(cv, co);
    ent_t h   = emp ? z : q[0];
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == D));
    chk("empty", 64'(empty), 64'(emp));
    chk("head_valid", 64'(bif.head_valid), 64'(!emp));
    chk("head_pc", 64'(bif.head_pc), 64'(h.pc));
    chk("head_gh", 64'(bif.head_ghistory), 64'(h.gh));
    chk("head_gs", 64'(bif.head_pred_gshare), 64'(h.g));
    chk("head_2b", 64'(bif.head_pred_2bit), 64'(h.b));
    chk("mispredict", 64'(bif.mispredict), 64'(mi));
    chk("recovery", 64'(bif.recovery_target),
        mi ? 64'(h.tgt) : 64'(0));
    chk("alloc_ready", 64'(bif.alloc_ready),
        64'(q.size() != D && !fl));
    chk("alloc_tag", 64'(bif.alloc_tag), 64'(m_wr));
    chk("err_uf", 64'(err_underflow), 64'(m_err));
    chk("commit_cnt", 64'(commit_cnt), 64'(m_ccnt));
    chk("mis_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
  endtask

  task automatic model_update(input bit av, input ent_t e,
                              input bit cv, input bit co,
                              input bit fl);
    bit emp = (q.size() == 0);
    bit mi  = m_mis(cv, co);
    bit aa  = av && q.size() != D && !fl && !mi;
    int rd  = (m_wr - q.size() + D) % D;
    if (cv && emp) m_err = 1;
    if (cv && !emp && m_ccnt != 64'hFFFF_FFFF) m_ccnt++;
    if (mi && m_mcnt != 64'hFFFF_FFFF) m_mcnt++;
    if (fl) begin
      q.delete();
      m_wr = rd;
    end else if (mi) begin
      q.delete();
    end else begin
      if (cv && !emp) void'(q.pop_front());
      if (aa) begin
        q.push_back(e);
        m_wr = (m_wr + 1) % D;
      end
    end
  endtask

  task automatic drive(input bit av, input ent_t e,
                       input bit cv, input bit co,
                       input bit fl);
    bif.alloc_valid           = av;
    bif.alloc_pc              = e.pc;
    bif.alloc_ghistory        = e.gh;
    bif.alloc_pred            = e.pred;
    bif.alloc_pred_gshare     = e.g;
    bif.alloc_pred_2bit       = e.b;
    bif.alloc_recovery_target = e.tgt;
    bif.commit_valid          = cv;
    bif.commit_outcome        = co;
    bif.flush_in              = fl;
  endtask

  task automatic step(input bit av, input ent_t e,
                      input bit cv, input bit co,
                      input bit fl);
    drive(av, e, cv, co, fl);
    @(negedge clk);
    check_all(cv, co, fl);
    model_update(av, e, cv, co, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    drive(0, z, 0, 0, 0);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_wr   = 0;
    m_err  = 0;
    m_ccnt = 0;
    m_mcnt = 0;
  endtask

  initial begin
    ent_t e;
    z = '{pc: 0, gh: 0, pred: 0, g: 0, b: 0, tgt: 0};
    drive(0, z, 0, 0, 0);
    #1;
    check_all(0, 0, 0);
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_ready", 64'(bif.alloc_ready), 64'(1));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    step(1, mk(32'h100, 1, 32'h500), 0, 0, 0);
    chk("tag1", 64'(bif.alloc_tag), 64'(1));
    step(1, mk(32'h104, 0, 32'h504), 0, 0, 0);
    step(1, mk(32'h108, 1, 32'h508), 0, 0, 0);
    settle();
    chk("tag3", 64'(bif.alloc_tag), 64'(3));
    chk("cnt3", 64'(count), 64'(3));
    chk("head100", 64'(bif.head_pc), 64'(32'h100));

    step(0, z, 1, 1, 0);
    step(0, z, 1, 0, 0);
    settle();
    chk("cnt1", 64'(count), 64'(1));
    chk("head108", 64'(bif.head_pc), 64'(32'h108));
    chk("ccnt2", 64'(commit_cnt), 64'(2));

    for (int i = 0; i < 15; i++) step(1, rnd(), 0, 0, 0);
    settle();
    chk("full1", 64'(full), 64'(1));
    chk("rdy0", 64'(bif.alloc_ready), 64'(0));
    step(1, rnd(), 1, q[0].pred, 0);
    settle();
    chk("cnt15", 64'(count), 64'(15));
    for (int i = 0; i < 40; i++)
      step(1, rnd(), 1, q[0].pred, 0);
    for (int i = 0; i < D && q.size() > 0; i++)
      step(0, z, 1, q[0].pred, 0);

    step(1, mk(32'h300, 1, 32'h200), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, rnd(), 0, 0, 0);
    e = rnd();
    drive(1, e, 1, 0, 0);
    #1;
    chk("mis1", 64'(bif.mispredict), 64'(1));
    chk("rtgt", 64'(bif.recovery_target), 64'(32'h200));
    step(1, e, 1, 0, 0);
    settle();
    chk("mis_cnt0", 64'(count), 64'(0));
    chk("mis_empty", 64'(empty), 64'(1));
    chk("mcnt1", 64'(mispredict_cnt), 64'(1));

    step(0, z, 1, 0, 0);
    step(0, z, 0, 0, 0);
    step(0, z, 0, 0, 0);
    settle();
    chk("uf", 64'(err_underflow), 64'(1));
    chk("uf_cnt", 64'(count), 64'(0));

    for (int i = 0; i < 5; i++) step(1, rnd(), 0, 0, 0);
    step(0, z, 0, 0, 1);
    settle();
    chk("flush_cnt", 64'(count), 64'(0));

    for (int i = 0; i < 400; i++) begin
      bit av = ($urandom % 3) != 0;
      bit cv, co, fl;
      if (q.size() > 0) begin
        cv = 1'($urandom);
        co = (($urandom % 5) == 0) ? !q[0].pred : q[0].pred;
      end else begin
        cv = ($urandom % 16) == 0;
        co = 1'($urandom);
      end
      fl = ($urandom % 25) == 0;
      step(av, rnd(), cv, co, fl);
    end

    for (int i = 0; i < 6; i++) step(1, rnd(), 0, 0, 0);
    drive(1, rnd(), 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all(0, 0, 0);
    drive(0, z, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1, rnd(), 0, 0, 0);
    step(0, z, 1, q[0].pred, 0);
    step(0, z, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_info_queue.md
Name: branch_info_queue

Overview:
- In-order circular queue of branch-prediction metadata for the OOO core.
- One entry is allocated at decode for each conditional branch. The head entry is released when the ROB commits that branch.
- On commit the block compares the resolved outcome against the stored prediction. It raises mispredict with the recovery target, the predictor-update fields and a full squash of younger entries.
- Sits between decoder/branch_controller (alloc side) and the ROB branch-commit path. The hazard controller consumes it.

Parameters:
DEPTH, 16, entry count; power of two; equals ROB depth.
PTR_W, $clog2(DEPTH), pointer width.
PC_W, 32, PC / target width.
GHIST_W, 8, global history width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
alloc_valid  in  1  decoder presents a conditional branch this cycle.
alloc_pc  in  PC_W  branch PC.
alloc_ghistory  in  GHIST_W  history used for the prediction.
alloc_pred  in  1  final prediction (1 = taken).
alloc_pred_gshare  in  1  gshare component prediction.
alloc_pred_2bit  in  1  bimodal component prediction.
alloc_recovery_target  in  PC_W  PC to fetch if the prediction is wrong.
alloc_ready  out  1  entry can be accepted (= !full & !flush_in).
alloc_tag  out  PTR_W  index the entry will occupy (= wr_ptr).
commit_valid  in  1  ROB commits the oldest branch.
commit_outcome  in  1  resolved direction.
flush_in  in  1  external full squash (jump-register redirect).
head_valid  out  1  queue non-empty.
head_pc  out  PC_W  head field; 0 when empty.
head_ghistory  out  GHIST_W  head field; 0 when empty.
head_pred_gshare  out  1  head field; 0 when empty.
head_pred_2bit  out  1  head field; 0 when empty.
mispredict  out  1  commit_valid & head_valid & (commit_outcome != head pred); combinational.
recovery_target  out  PC_W  head recovery target while mispredict=1, else 0.
count  out  PTR_W+1  occupied entries.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
err_underflow  out  1  sticky: commit arrived while empty.
commit_cnt  out  32  saturating count of accepted commits.
mispredict_cnt  out  32  saturating count of mispredicts.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr = rd_ptr = 0, count = 0; array cleared.
  - err_underflow = 0, both counters 0.
  - Outputs immediately: empty=1, full=0, head_valid=0, mispredict=0, alloc_ready=1, alloc_tag=0.
  - Reset asserted mid-operation discards all entries in the same instant.
- Alloc accept: alloc_valid & !full & !flush_in & !mispredict.
  - The accepted entry is written at wr_ptr on the clock edge; wr_ptr increments modulo DEPTH.
  - Earliest visibility at the head is the next cycle; no same-cycle bypass.
- Commit accept: commit_valid & !empty.
  - rd_ptr increments modulo DEPTH; commit_cnt increments, saturating at 0xFFFFFFFF.
- Commit while empty:
  - No pointer change and no mispredict.
  - err_underflow sets and holds until reset.
- Mispredict (accepted commit with outcome != pred):
  - mispredict_cnt increments, saturating.
  - At the edge all younger entries are squashed: rd_ptr <= wr_ptr, count <= 0.
  - Any alloc in that cycle is dropped (alloc_ready is still high; alloc_ready does not factor mispredict, and the bench must not assume acceptance).
- flush_in=1: wr_ptr <= rd_ptr, count <= 0, no alloc.
  - A simultaneous accepted commit is still counted.
  - Its mispredict output is still driven, but squash results are identical.
- Simultaneous alloc + non-mispredicting commit: both take effect; count is unchanged.
- Full: alloc_ready=0 even if a commit pops the same cycle, because full is registered.
- count always equals (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal and the queue is full.
- All head outputs and mispredict are combinational from state plus commit inputs. All other outputs are registered state.

Test Plan:
- Reset, then alloc 3 branches (pc 0x100/0x104/0x108, pred 1/0/1) on consecutive cycles -> count=3, alloc_tag 0,1,2, then 3; head_pc=0x100 one cycle after first alloc.
- Commit outcomes 1,0 matching predictions -> no mispredict, count 3->1, head_pc=0x108, commit_cnt=2.
- Fill 16 entries -> full=1, alloc_ready=0. Alloc+commit same cycle -> alloc refused, count=15. Continue 40 alloc/commit pairs -> pointers wrap, FIFO order preserved.
- Head pred=1, recovery 0x200, commit_outcome=0 with 4 entries and alloc_valid=1 -> mispredict=1 and recovery_target=0x200 same cycle; next cycle count=0, empty=1, mispredict_cnt=1.
- commit_valid while empty -> err_underflow=1 persistently, count stays 0.
- 5 entries, flush_in=1 -> count=0 next cycle. Assert rst_n=0 mid-burst between edges -> outputs reset immediately.
